// File: rtl/issue_pair_packer.sv
// Buffers in-order 16-bit instructions and packs up to two per cycle into an ALU/mem-branch bundle.
// Optional macro PAIR_RAW_CHECK_EN blocks pairing across a register dependency.
module issue_pair_packer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  opcode1,
    output logic [4:0]  opcode2,
    output logic [1:0]  out_count
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_SUB = 5'b00011;
    localparam logic [4:0] OP_CMP = 5'b01000;
    localparam logic [4:0] OP_LD  = 5'b10001;
    localparam logic [4:0] OP_ST  = 5'b10000;
    localparam logic [4:0] OP_JMP = 5'b11100;
    localparam logic [4:0] OP_BR  = 5'b11010;
`ifdef PAIR_RAW_CHECK_EN
    localparam bit RAW_EN = 1'b1;
`else
    localparam bit RAW_EN = 1'b0;
`endif

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [15:0]       head, nxt;
    logic [4:0]        h_op, n_op;
    logic              has_next, dep_hit, raw_fwd, raw_bwd;
    logic              pair, swap, load, push;
    logic [CNT_W-1:0]  pop_n;
    logic [6:0]        nxt_op1;
    logic [4:0]        nxt_op2;
    logic              unused_bits;

    function automatic logic is_g1(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

    function automatic logic is_g2(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ST) || (op == OP_JMP) || (op == OP_BR);
    endfunction

    assign head     = mem[rd_ptr];
    assign nxt      = mem[rd_ptr + ADDR_W'(1)];
    assign h_op     = head[15:11];
    assign n_op     = nxt[15:11];
    assign has_next = count >= CNT_W'(2);
    assign in_ready = (count != CNT_W'(DEPTH)) && !flush;
    assign push     = in_valid && in_ready;
    assign load     = (!out_valid || out_ready) && (count != '0) && !flush;
    assign unused_bits = ^{head[7:2], nxt[10:8]};

    // Younger reads (rs/rt) against the older writer's rd
    assign dep_hit = (nxt[7:5] == head[10:8]) || (nxt[4:2] == head[10:8]);
    assign raw_fwd = RAW_EN && dep_hit;
    assign raw_bwd = RAW_EN && dep_hit && (h_op == OP_LD);

    // Pairing decision; control transfers never take a younger partner
    always_comb begin
        pair = 1'b0;
        swap = 1'b0;
        if (has_next) begin
            if (is_g1(h_op) && is_g2(n_op) && !raw_fwd) begin
                pair = 1'b1;
            end else if ((h_op == OP_LD || h_op == OP_ST) && is_g1(n_op) && !raw_bwd) begin
                pair = 1'b1;
                swap = 1'b1;
            end
        end
    end

    // Slot contents; NP yields an all-zero bundle, UNK goes to slot 2
    always_comb begin
        nxt_op1 = '0;
        nxt_op2 = '0;
        if (pair && swap) begin
            nxt_op1 = {n_op, nxt[1:0]};
            nxt_op2 = h_op;
        end else if (pair) begin
            nxt_op1 = {h_op, head[1:0]};
            nxt_op2 = n_op;
        end else if (is_g1(h_op)) begin
            nxt_op1 = {h_op, head[1:0]};
        end else begin
            nxt_op2 = h_op;
        end
    end

    assign pop_n = load ? (pair ? CNT_W'(2) : CNT_W'(1)) : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_instr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + ADDR_W'(push);
            rd_ptr <= rd_ptr + ADDR_W'(pop_n);
            count  <= count + CNT_W'(push) - pop_n;
        end
    end

    // Bundle register: holds while stalled, clears when consumed with nothing to reload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            opcode1   <= '0;
            opcode2   <= '0;
            out_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            opcode1   <= '0;
            opcode2   <= '0;
            out_count <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            opcode1   <= nxt_op1;
            opcode2   <= nxt_op2;
            out_count <= pair ? 2'd2 : 2'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            opcode1   <= '0;
            opcode2   <= '0;
            out_count <= '0;
        end
    end
endmodule
